// File: rtl/uart_tx_shifter.sv
//----------------------------------------------------------------------------
// Module  : uart_tx_shifter
// Brief   : UART transmit shifter. It sends a start bit, 8 data bits LSB
//           first and a stop bit, plus an even-parity bit when
//           UART_TX_PARITY_EN is defined.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module uart_tx_shifter #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [7:0]           data_in,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t               r_state;
  logic [7:0]           r_shift;
  logic [2:0]           r_bit;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_cnt;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif
  logic                 w_bit_end;

  // r_div is never zero, so the subtraction cannot wrap
  assign w_bit_end = (r_cnt == (r_div - DIV_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shift  <= 8'd0;
      r_bit    <= 3'd0;
      r_div    <= DIV_WIDTH'(1);
      r_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_state == IDLE) begin
        tx   <= 1'b1;
        busy <= 1'b0;
        if (load) begin
          r_state  <= START;
          r_shift  <= data_in;
          r_div    <= (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
          r_cnt    <= '0;
          r_bit    <= 3'd0;
`ifdef UART_TX_PARITY_EN
          r_parity <= ^data_in;
`endif
          tx       <= 1'b0;
          busy     <= 1'b1;
        end
      end else if (!w_bit_end) begin
        r_cnt <= r_cnt + DIV_WIDTH'(1);
      end else begin
        r_cnt <= '0;
        case (r_state)
          START: begin
            r_state <= DATA;
            tx      <= r_shift[0];
          end
          DATA: begin
            if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              tx      <= r_parity;
`else
              r_state <= STOP;
              tx      <= 1'b1;
`endif
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              tx      <= r_shift[1];
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            r_state <= STOP;
            tx      <= 1'b1;
          end
`endif
          STOP: begin
            r_state <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
          default: begin
            r_state <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_shifter.md
UART_TX_SHIFTER -- requirements
Module: uart_tx_shifter

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, the width of the baud divisor input.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port load  input  1  one-cycle request to start a frame with data_in; driven by the TX control FSM's load output.
REQ-005 SHALL have port data_in  input  8  byte to transmit; the FIFO read data.
REQ-006 SHALL have port baud_div  input  DIV_WIDTH  clock cycles per serial bit.
REQ-007 SHALL have port tx  output  1  serial line; idles high.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a frame completes.

Function
REQ-010 SHALL implement states IDLE, START, DATA, PARITY (macro-dependent) and STOP.
REQ-011 SHALL, when load=1 is sampled in IDLE at edge k, capture data_in and capture baud_div; an effective divisor of 0 SHALL be treated as 1.
REQ-012 SHALL, after that edge k, enter START with tx=0 and busy=1 (tx and busy are registered outputs).
REQ-013 SHALL hold each bit on tx for exactly the captured divisor number of cycles, using an internal bit-period counter.
REQ-014 SHALL send the 8 data bits LSB first in DATA, using a 3-bit index; index 7 completing SHALL advance to PARITY or STOP.
REQ-015 SHALL drive tx=1 for one bit period in STOP.
REQ-016 SHALL, at the edge ending STOP, return to IDLE, set tx=1 and busy=0, and assert done=1 for exactly one cycle.
REQ-017 SHALL ignore load while busy=1: no capture, and the frame in progress is unaffected.
REQ-018 SHALL accept a load sampled in the cycle where done=1 (state is IDLE), so back-to-back frames have zero idle gap.
REQ-019 SHALL keep data_in and baud_div changes during a frame from affecting that frame.
REQ-020 SHALL keep tx glitch-free; it changes only at bit-period boundaries.

Reset
REQ-021 SHALL, when rst=1 at a rising edge, set state=IDLE, tx=1, busy=0, done=0, and clear the counters and shift register.
REQ-022 SHALL, if reset occurs mid-frame, abort the frame with tx=1 from the next edge and no done pulse.
REQ-023 SHALL give rst priority over a simultaneous load.

Configuration
REQ-024 SHALL, with UART_TX_PARITY_EN defined, insert a PARITY state after DATA that drives the even-parity bit (XOR of the 8 data bits) for one bit period; frame length is then 11 bit periods.
REQ-025 SHALL, with UART_TX_PARITY_EN undefined, omit the PARITY state and logic entirely; the frame is 10 bit periods (8N1).

Verification
REQ-026 Bench SHALL cover: baud_div=4, load with data_in=0xA5, parity off -> tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy high for 40 cycles; done pulses at cycle 40 after the load edge.
REQ-027 Bench SHALL cover: UART_TX_PARITY_EN, baud_div=2, data_in=0x07 -> parity bit 1, frame 22 cycles, stop bit high.
REQ-028 Bench SHALL cover: baud_div=0, data_in=0xFF -> each bit lasts 1 cycle; frame 10 cycles.
REQ-029 Bench SHALL cover: load pulsed again mid-frame with 0x00 -> ignored; original byte completes unchanged.
REQ-030 Bench SHALL cover: load asserted during the done cycle with 0x3C -> a new start bit begins on the next edge with no idle gap.
REQ-031 Bench SHALL cover: rst asserted in DATA bit 3 -> tx=1, busy=0, done=0 after the edge; a subsequent load transmits normally.
